// File: rtl/pcie_dma_writer_if.sv
// Register port, payload source stream, Avalon-ST TLP transmit and MSI handshake
// of the upstream DMA writer.
interface pcie_dma_writer_if;
    logic [15:0] cfgBusDev_in;
    logic        regWrValid_in;
    logic [1:0]  regWrAddr_in;
    logic [31:0] regWrData_in;
    logic [1:0]  regRdAddr_in;
    logic [31:0] regRdData_out;
    logic [63:0] srcData_in;
    logic        srcValid_in;
    logic        srcReady_out;
    logic [63:0] txData_out;
    logic        txValid_out;
    logic        txSop_out;
    logic        txEop_out;
    logic        txReady_in;
    logic        msiReq_out;
    logic        msiAck_in;

    modport master (
        input  cfgBusDev_in, regWrValid_in, regWrAddr_in, regWrData_in, regRdAddr_in,
               srcData_in, srcValid_in, txReady_in, msiAck_in,
        output regRdData_out, srcReady_out, txData_out, txValid_out, txSop_out,
               txEop_out, msiReq_out
    );

    modport slave (
        output cfgBusDev_in, regWrValid_in, regWrAddr_in, regWrData_in, regRdAddr_in,
               srcData_in, srcValid_in, txReady_in, msiAck_in,
        input  regRdData_out, srcReady_out, txData_out, txValid_out, txSop_out,
               txEop_out, msiReq_out
    );
endinterface

// File: rtl/pcie_dma_writer.sv
// Upstream DMA engine: streams N payload TLPs from a buffered source into host memory,
// then writes a completion token at the base address and raises an MSI request.
module pcie_dma_writer #(
    parameter int          TLP_QWS     = 16,
    parameter int          COUNT_WIDTH = 16,
    parameter int          DATA_OFFSET = 64,
    parameter logic [63:0] TOKEN       = 64'hCAFEF00DC0DEFACE
) (
    input logic               clk_in,
    input logic               reset_in,
    pcie_dma_writer_if.master bus
);
    localparam int DEPTH = 2 * TLP_QWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int QW_W  = (TLP_QWS > 1) ? $clog2(TLP_QWS) : 1;
    localparam int FW    = COUNT_WIDTH + $clog2(TLP_QWS) + 1;

    typedef enum logic [3:0] {IDLE, FILL, HDR0, HDR1, DATA, THDR0, THDR1, TDATA, MSI} state_t;
    state_t state, state_nxt;

    logic [63:0]            mem [DEPTH];
    logic [AW-1:0]          wptr, rptr;
    logic [AW:0]            count, count_nxt;
    logic [FW-1:0]          fetch_rem;
    logic [COUNT_WIDTH-1:0] remaining, wr_count;
    logic [31:0]            base, addr, h0, h1;
    logic [QW_W-1:0]        qw_cnt;
    logic                   err, busy, start, push, pop, tx_fire, last_beat;

    assign busy      = (state != IDLE);
    assign wr_count  = bus.regWrData_in[COUNT_WIDTH-1:0];
    assign start     = bus.regWrValid_in & ~busy & (bus.regWrAddr_in == 2'd1) & (wr_count != '0);
    assign bus.srcReady_out = busy & (fetch_rem != '0) & (count != (AW+1)'(DEPTH));
    assign push      = bus.srcValid_in & bus.srcReady_out;
    assign tx_fire   = bus.txValid_out & bus.txReady_in;
    assign pop       = (state == DATA) & tx_fire;
    assign last_beat = pop & (qw_cnt == QW_W'(TLP_QWS - 1));
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    assign h0        = 32'h4000_0000 | 32'(2 * TLP_QWS);
    assign h1        = {bus.cfgBusDev_in, 8'h00, 8'hFF};
    assign bus.msiReq_out = (state == MSI);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nxt;
    end

    // Skipping FILL when the next TLP is already buffered keeps payload TLPs back to back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FILL;
            FILL:  if (count >= (AW+1)'(TLP_QWS)) state_nxt = HDR0;
            HDR0:  if (tx_fire) state_nxt = HDR1;
            HDR1:  if (tx_fire) state_nxt = DATA;
            DATA:  if (last_beat) begin
                       if (remaining != COUNT_WIDTH'(1))
                           state_nxt = (count_nxt >= (AW+1)'(TLP_QWS)) ? HDR0 : FILL;
                       else
                           state_nxt = THDR0;
                   end
            THDR0: if (tx_fire) state_nxt = THDR1;
            THDR1: if (tx_fire) state_nxt = TDATA;
            TDATA: if (tx_fire) state_nxt = MSI;
            MSI:   if (bus.msiAck_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.txValid_out = 1'b1;
        bus.txSop_out   = 1'b0;
        bus.txEop_out   = 1'b0;
        bus.txData_out  = '0;
        case (state)
            HDR0:  begin bus.txSop_out = 1'b1; bus.txData_out = {h1, h0}; end
            HDR1:  bus.txData_out = {32'h0, addr};
            DATA:  begin
                       bus.txData_out = mem[rptr];
                       bus.txEop_out  = (qw_cnt == QW_W'(TLP_QWS - 1));
                   end
            THDR0: begin bus.txSop_out = 1'b1; bus.txData_out = {h1, 32'h4000_0002}; end
            THDR1: bus.txData_out = {32'h0, base};
            TDATA: begin bus.txEop_out = 1'b1; bus.txData_out = TOKEN; end
            default: bus.txValid_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            fetch_rem <= '0;
            remaining <= '0;
            base      <= '0;
            addr      <= '0;
            qw_cnt    <= '0;
            err       <= 1'b0;
            bus.regRdData_out <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wptr      <= wptr + AW'(1);
                fetch_rem <= fetch_rem - FW'(1);
            end
            if (pop) begin
                rptr   <= rptr + AW'(1);
                qw_cnt <= last_beat ? '0 : qw_cnt + QW_W'(1);
            end
            if (last_beat) begin
                remaining <= remaining - COUNT_WIDTH'(1);
                addr      <= addr + 32'(8 * TLP_QWS);
            end
            // Writes while a transfer runs never disturb it; they only flag the misuse.
            if (bus.regWrValid_in) begin
                if (busy)
                    err <= 1'b1;
                else if (bus.regWrAddr_in == 2'd0)
                    base <= {bus.regWrData_in[31:3], 3'b000};
                else if (start) begin
                    remaining <= wr_count;
                    fetch_rem <= FW'(wr_count) << $clog2(TLP_QWS);
                    addr      <= base + 32'(DATA_OFFSET);
                    err       <= 1'b0;
                end
            end
            case (bus.regRdAddr_in)
                2'd0:    bus.regRdData_out <= base;
                2'd1:    bus.regRdData_out <= 32'(remaining);
                2'd2:    bus.regRdData_out <= {30'b0, err, busy};
                default: bus.regRdData_out <= '0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wptr] <= bus.srcData_in;
    end
endmodule
